regfile_writeback: RTL and testbench

Write-side front end for the 16×16-bit register file. Merges single-cycle ALU results and variable-latency load results into the file's single write port (`we3`/`wa3`/`wd3`). ALU results get fixed priority. Load results are buffered in a small FIFO with a valid/ready handshake. Queued loads made stale by a younger ALU write to the same register are killed. Writes to r0 are dropped.

---
 rtl/regfile_writeback.sv | 171 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register file write front end: ALU results get priority, loads drain from a small FIFO, queued loads made stale by a younger ALU write are killed.
// Latency: ALU result in N is written in N+1; a load accepted into an empty FIFO in N is written in N+2 if the ALU is idle in N+1.
// Backpressure: ALU is never stalled; ld_ready = !full && !rst. Optional REGFILE_WB_STATS_EN adds saturating commit/kill counters.
module regfile_writeback #(
    parameter  int DATA_W     = 16,
    parameter  int ADDR_W     = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic [CNT_W-1:0]  pend_cnt
`ifdef REGFILE_WB_STATS_EN
    ,
    output logic [15:0]       stat_alu_wr,
    output logic [15:0]       stat_ld_wr,
    output logic [15:0]       stat_kill
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Load buffer storage; a cleared live bit marks an entry killed (or a free slot).
    logic [ADDR_W-1:0]     mem_a_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_d_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    logic alu_sel, fifo_empty, fifo_full, head_live, ld_acc, push, pop;
    logic [CNT_W:0] kill_n;

    assign alu_sel    = alu_valid && (alu_rd != '0);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign head_live  = !fifo_empty && live_q[rd_ptr_q];
    assign ld_ready   = !fifo_full && !rst;
    assign ld_acc     = ld_valid && ld_ready;
    // Dead heads drain only in cycles the ALU leaves the write port idle.
    assign pop        = !alu_sel && !fifo_empty;
    // r0 loads and loads superseded by this cycle's ALU write are swallowed.
    assign push       = ld_acc && (ld_rd != '0) && !(alu_sel && (ld_rd == alu_rd));

    // Write-port select and FIFO pointer/occupancy/live-bit next state.
    always_comb begin
        we3_d    = 1'b0;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        kill_n   = '0;

        if (alu_sel) begin
            we3_d = 1'b1;
            wa3_d = alu_rd;
            wd3_d = alu_data;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (live_q[i] && (mem_a_q[i] == alu_rd)) begin
                    live_d[i] = 1'b0;
                    kill_n    = kill_n + 1'b1;
                end
            end
            if (ld_acc && (ld_rd == alu_rd)) begin
                kill_n = kill_n + 1'b1;
            end
        end else if (head_live) begin
            we3_d = 1'b1;
            wa3_d = mem_a_q[rd_ptr_q];
            wd3_d = mem_d_q[rd_ptr_q];
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry payload needs no reset: a slot is only read while its live bit is set.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_a_q[wr_ptr_q] <= ld_rd;
            mem_d_q[wr_ptr_q] <= ld_data;
        end
    end

    // Live-entry count for pend_cnt; free and killed slots have live cleared.
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pend_cnt = pend_cnt + CNT_W'(live_q[i]);
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

`ifdef REGFILE_WB_STATS_EN
    logic [15:0] st_alu_q, st_ld_q, st_kill_q;
    logic [16:0] kill_sum;

    assign kill_sum = {1'b0, st_kill_q} + 17'(kill_n);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_alu_q  <= '0;
            st_ld_q   <= '0;
            st_kill_q <= '0;
        end else begin
            if (alu_sel && (st_alu_q != 16'hFFFF)) st_alu_q <= st_alu_q + 1'b1;
            if (pop && head_live && (st_ld_q != 16'hFFFF)) st_ld_q <= st_ld_q + 1'b1;
            st_kill_q <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
        end
    end

    assign stat_alu_wr = st_alu_q;
    assign stat_ld_wr  = st_ld_q;
    assign stat_kill   = st_kill_q;
`else
    logic unused_kill;
    assign unused_kill = ^kill_n;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, checked against a queue model.
module tb_regfile_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [15:0] ld_data;
    logic        we3;
    logic [3:0]  wa3;
    logic [15:0] wd3;
    logic [1:0]  pend_cnt;

    regfile_writeback #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        e_we;
    logic [3:0]  e_wa;
    logic [15:0] e_wd;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (q[i]) if (q[i].live) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, check ld_ready, advance the model, check registered outputs.
    task automatic step(input bit r, input bit av, input logic [3:0] ar, input logic [15:0] ad,
                        input bit lv, input logic [3:0] lr, input logic [15:0] ld);
        bit   exp_rdy, acc, sel;
        ent_t e;
        rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ld;
        #1;
        exp_rdy = !r && (q.size() < DEPTH);
        chk("ld_ready", ld_ready, exp_rdy);
        if (r) begin
            q.delete();
            e_we = 0; e_wa = 0; e_wd = 0;
        end else begin
            acc = lv && exp_rdy;
            sel = av && (ar != 0);
            e_we = 0;
            if (sel) begin
                e_we = 1; e_wa = ar; e_wd = ad;
                foreach (q[i]) if (q[i].a == ar) q[i].live = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.live) begin
                    e_we = 1; e_wa = e.a; e_wd = e.d;
                end
            end
            if (acc && lr != 0 && !(sel && lr == ar)) begin
                e.a = lr; e.d = ld; e.live = 1;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("we3", we3, e_we);
        chk("wa3", wa3, e_wa);
        chk("wd3", wd3, e_wd);
        chk("pend_cnt", pend_cnt, live_count());
    endtask

    initial begin
        e_we = 0; e_wa = 0; e_wd = 0;
        // Reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // ALU only: r3=0x1234
        step(0, 1, 3, 16'h1234, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Load during ALU burst
        step(0, 1, 1, 16'h0001, 1, 5, 16'hBEEF);
        step(0, 1, 2, 16'h0002, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("burst_r5", wd3, 16'hBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        // Kill: r7 queued, ALU r7 before the pop
        step(0, 1, 1, 16'h0011, 1, 7, 16'h00AA);
        step(0, 1, 7, 16'h0055, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("kill_silent", we3, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Full back-pressure
        step(0, 1, 1, 16'h0101, 1, 8, 16'h0808);
        step(0, 1, 2, 16'h0202, 1, 9, 16'h0909);
        step(0, 1, 3, 16'h0303, 1, 10, 16'h0A0A);
        step(0, 1, 4, 16'h0404, 1, 10, 16'h0A0A);
        step(0, 0, 0, 0, 1, 10, 16'h0A0A);
        step(0, 0, 0, 0, 1, 10, 16'h0A0A);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // r0 handling
        step(0, 1, 1, 16'h1111, 1, 4, 16'h4444);
        step(0, 1, 0, 16'hFFFF, 0, 0, 0);
        chk("r0_pop_r4", wa3, 4'd4);
        step(0, 0, 0, 0, 1, 0, 16'h7777);
        step(0, 0, 0, 0, 0, 0, 0);
        // Reset mid-operation with two loads queued
        step(0, 1, 1, 16'h0001, 1, 11, 16'hB0B0);
        step(0, 1, 2, 16'h0002, 1, 12, 16'hC0C0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Random traffic, small address range to provoke kills and r0 cases
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 5)), 16'($urandom),
                 ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 5)), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
